// File: rtl/reg_file_bypass.sv
// Register file with two read ports, write-to-read bypass and a per-register
// pending (scoreboard) bit, with an optional registered read path.
module reg_file_bypass #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int READ_REG = 0,
    parameter int ZERO_R0  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_id,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              lock,
    input  logic [ADDR_W-1:0] lock_id,
    input  logic [ADDR_W-1:0] rd_id1,
    input  logic [ADDR_W-1:0] rd_id2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_pend1,
    output logic              rd_pend2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  wr_hot;
    logic [DEPTH-1:0]  lock_hot;
    logic [DATA_W-1:0] byp1;
    logic [DATA_W-1:0] byp2;

    // One-hot decode; a hardwired-zero r0 is simply never selected.
    always_comb begin
        wr_hot   = '0;
        lock_hot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            wr_hot[k]   = we && (wr_id == ADDR_W'(k));
            lock_hot[k] = lock && (lock_id == ADDR_W'(k));
        end
        if (ZERO_R0 != 0) begin
            wr_hot[0]   = 1'b0;
            lock_hot[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (wr_hot[k]) begin
                    regs[k] <= wr_data;
                end
            end
        end
    end

    // Lock has priority over the clear caused by a write to the same id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (lock_hot[k]) begin
                    pend[k] <= 1'b1;
                end else if (wr_hot[k]) begin
                    pend[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        byp1 = wr_hot[rd_id1] ? wr_data : regs[rd_id1];
        byp2 = wr_hot[rd_id2] ? wr_data : regs[rd_id2];
    end

    // A write in flight makes the bypassed data valid, so it hides pending.
    assign rd_pend1 = pend[rd_id1] & ~(we && (wr_id == rd_id1));
    assign rd_pend2 = pend[rd_id2] & ~(we && (wr_id == rd_id2));

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] rd_data1_p1;
            logic [DATA_W-1:0] rd_data2_p1;

            // Stage p1: read data captured with same-edge write bypass
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data1_p1 <= '0;
                    rd_data2_p1 <= '0;
                end else begin
                    rd_data1_p1 <= byp1;
                    rd_data2_p1 <= byp2;
                end
            end

            assign rd_data1 = rd_data1_p1;
            assign rd_data2 = rd_data2_p1;
        end else begin : g_rd_comb
            assign rd_data1 = byp1;
            assign rd_data2 = byp2;
        end
    endgenerate

endmodule

// File: doc/reg_file_bypass.md
REG_FILE_BYPASS -- requirements
Module: reg_file_bypass

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, register-id width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter READ_REG, default 0; 0 = combinational read, 1 = registered read (one-cycle latency).
REQ-004 SHALL have parameter ZERO_R0, default 1; 1 = register 0 reads 0 and ignores writes.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port we, input, 1, write enable.
REQ-008 SHALL have port wr_id, input, ADDR_W, write register id.
REQ-009 SHALL have port wr_data, input, DATA_W, write data.
REQ-010 SHALL have port lock, input, 1, marks register lock_id as pending a write.
REQ-011 SHALL have port lock_id, input, ADDR_W, register to mark pending.
REQ-012 SHALL have ports rd_id1 and rd_id2, input, ADDR_W each, read register ids.
REQ-013 SHALL have ports rd_data1 and rd_data2, output, DATA_W each, read data.
REQ-014 SHALL have ports rd_pend1 and rd_pend2, output, 1 each, pending flag of the addressed register.

Function
REQ-015 Write: when we=1, register wr_id SHALL take wr_data at the clock edge; id decode is one-hot across all 2**ADDR_W entries.
REQ-016 When ZERO_R0=1, writes to id 0 SHALL be discarded; reads of id 0 SHALL return 0 with pend 0.
REQ-017 READ_REG=0: rd_dataN SHALL combinationally reflect register rd_idN in the same cycle.
REQ-018 READ_REG=0 bypass: if we=1 and wr_id==rd_idN (excluding id 0 when ZERO_R0=1), rd_dataN SHALL equal wr_data in that cycle.
REQ-019 READ_REG=1: rd_dataN SHALL be captured at the edge and present the value of rd_idN sampled at that edge, including the same-edge write (bypass), i.e. latency 1.
REQ-020 Both read ports SHALL be independent; rd_id1==rd_id2 SHALL return identical data.
REQ-021 Scoreboard: lock=1 SHALL set pend[lock_id] at the edge; a write (we=1) SHALL clear pend[wr_id] at the edge.
REQ-022 Simultaneous lock and we to the same id SHALL leave pend=1 (lock wins); to different ids, both effects apply.
REQ-023 rd_pendN SHALL be combinational from pend[rd_idN] in both READ_REG modes, masked to 0 when we=1 and wr_id==rd_idN (write in flight, bypass valid).
REQ-024 lock of id 0 with ZERO_R0=1 SHALL be ignored.
REQ-025 Out-of-range ids cannot occur (depth is exactly 2**ADDR_W); no error output exists.

Reset
REQ-026 rst_n=0 SHALL immediately clear all registers, all pend bits, and (READ_REG=1) the read-data registers to 0, independent of clk.
REQ-027 During reset, we and lock SHALL have no effect; the first update occurs at the first rising edge after rst_n rises.
REQ-028 Reset asserted mid-write SHALL leave the target register 0.

Verification
REQ-029 Reset, then read ids 0..15 -> all rd_data 0, all rd_pend 0.
REQ-030 READ_REG=0, we=1 wr_id=5 wr_data=0xBEEF, rd_id1=5 same cycle -> rd_data1=0xBEEF that cycle; next cycle with we=0 still 0xBEEF.
REQ-031 READ_REG=1, write 0x1234 to id 3 with rd_id2=3 at the same edge -> rd_data2=0x1234 after that edge; one cycle earlier it showed the old value.
REQ-032 ZERO_R0=1, write 0xFFFF and lock to id 0 -> rd_data1=0, rd_pend1=0.
REQ-033 lock id 7; next cycle rd_id1=7 -> rd_pend1=1; lock and we to id 7 at the same edge -> pend stays 1; a later we alone to id 7 -> pend 0.
REQ-034 Write 0xAAAA to id 9, pulse rst_n low between clock edges -> rd_data for id 9 reads 0 immediately, pend 0.
